// File: rtl/sum_mod_vec_if.sv
// -----------------------------------------------------------------------------
// sum_mod_vec_if
//   Handshake bundle for the element-wise modular vector adder.
//   Input side : per-channel valid/ready beats carrying one element each.
//   Output side: one reduced element per out_valid/out_ready handshake.
// Signals
//   in_valid  [N_CH]         producer -> adder, per-channel beat valid
//   in_data   [N_CH*DATA_W]  producer -> adder, channel c at [c*DATA_W +: DATA_W]
//   in_ready  [N_CH]         adder -> producer, per-channel ready
//   out_valid                adder -> consumer, result element valid
//   out_ready                consumer -> adder, result element accepted
//   out_data  [DATA_W]       adder -> consumer, reduced element (< MODULUS)
//   out_index [IDX_W]        adder -> consumer, element position in the vector
//   out_last                 adder -> consumer, final element of the vector
// Modports: master = producer/consumer side, slave = adder side.
// -----------------------------------------------------------------------------
interface sum_mod_vec_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 9,
    parameter int IDX_W  = 3
);
    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic [IDX_W-1:0]       out_index;
    logic                   out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/sum_mod_vec.sv
// -----------------------------------------------------------------------------
// sum_mod_vec
//   Element-wise modular vector adder. N_CH channels each deliver one
//   VEC_LEN-element vector; element i of the result is the sum over channels
//   of element i, reduced mod MODULUS, streamed out with valid/ready.
//   Flow: COLLECT (accumulate beats) -> REDUCE (one compare-subtract per
//   cycle) -> OUTPUT (stream elements) -> COLLECT.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   flush  in   synchronous abort: drop the current vector, back to COLLECT
//   bus    slave modport of sum_mod_vec_if (input beats / result stream)
//   busy   out  high while reducing or streaming the result
// The interface instance must be built with the same N_CH, DATA_W and
// IDX_W = $clog2(VEC_LEN+1).
// -----------------------------------------------------------------------------
module sum_mod_vec #(
    parameter int N_CH    = 4,
    parameter int VEC_LEN = 6,
    parameter int DATA_W  = 9,
    parameter int MODULUS = 509
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    sum_mod_vec_if.slave bus,
    output logic         busy
);
    // One spare bit over the N_CH*(2**DATA_W-1) worst case.
    localparam int ACC_W = DATA_W + $clog2(N_CH) + 1;
    localparam int IDX_W = $clog2(VEC_LEN + 1);

    localparam logic [ACC_W-1:0] MOD_A  = ACC_W'(MODULUS);
    localparam logic [IDX_W-1:0] LEN_I  = IDX_W'(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {S_COLLECT, S_REDUCE, S_OUTPUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [ACC_W-1:0] r_acc [VEC_LEN];
    logic [IDX_W-1:0] r_cnt [N_CH];
    logic [IDX_W-1:0] r_ridx;
    logic [IDX_W-1:0] r_oidx;

    logic [N_CH-1:0]   w_ready;
    logic [N_CH-1:0]   w_take;
    logic              w_all_full;
    logic [ACC_W-1:0]  w_add [VEC_LEN];
    logic [ACC_W-1:0]  w_racc;
    logic [DATA_W-1:0] w_odata;
    logic              w_out_fire;
    logic              w_done;

    // Per-channel ready / accept, and "every channel has its full vector".
    always_comb begin
        w_ready    = '0;
        w_take     = '0;
        w_all_full = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            w_ready[c] = (r_state == S_COLLECT) && (r_cnt[c] < LEN_I);
            w_take[c]  = w_ready[c] && bus.in_valid[c];
            if (r_cnt[c] != LEN_I) w_all_full = 1'b0;
        end
    end

    // Channels advance independently, so several may land on the same
    // element in one cycle; sum every contribution per element.
    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            w_add[i] = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (w_take[c] && (r_cnt[c] == IDX_W'(i)))
                    w_add[i] = w_add[i] + ACC_W'(bus.in_data[c*DATA_W +: DATA_W]);
            end
        end
    end

    // Read muxes for the element under reduction and the element on output.
    // After reduction every accumulator is < MODULUS, so DATA_W bits hold it.
    always_comb begin
        w_racc  = '0;
        w_odata = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (r_ridx == IDX_W'(i)) w_racc  = r_acc[i];
            if (r_oidx == IDX_W'(i)) w_odata = r_acc[i][DATA_W-1:0];
        end
    end

    assign w_out_fire = (r_state == S_OUTPUT) && bus.out_ready;
    assign w_done     = w_out_fire && (r_oidx == LAST_I);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_COLLECT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_all_full) w_state_nxt = S_REDUCE;
            // Leave only once the last element is fully reduced.
            S_REDUCE:  if ((w_racc < MOD_A) && (r_ridx == LAST_I)) w_state_nxt = S_OUTPUT;
            S_OUTPUT:  if (w_done) w_state_nxt = S_COLLECT;
            default:   w_state_nxt = S_COLLECT;
        endcase
        if (flush) w_state_nxt = S_COLLECT;
    end

    // Accumulators, channel counters and indices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VEC_LEN; i++) r_acc[i] <= '0;
            for (int c = 0; c < N_CH; c++)    r_cnt[c] <= '0;
            r_ridx <= '0;
            r_oidx <= '0;
        end else if (flush || w_done) begin
            // Flush overrides any handshake in the same cycle.
            for (int i = 0; i < VEC_LEN; i++) r_acc[i] <= '0;
            for (int c = 0; c < N_CH; c++)    r_cnt[c] <= '0;
            r_ridx <= '0;
            r_oidx <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    for (int i = 0; i < VEC_LEN; i++) r_acc[i] <= r_acc[i] + w_add[i];
                    for (int c = 0; c < N_CH; c++)
                        if (w_take[c]) r_cnt[c] <= r_cnt[c] + IDX_W'(1);
                    r_ridx <= '0;
                end
                S_REDUCE: begin
                    if (w_racc >= MOD_A) begin
                        for (int i = 0; i < VEC_LEN; i++)
                            if (r_ridx == IDX_W'(i)) r_acc[i] <= w_racc - MOD_A;
                    end else if (r_ridx != LAST_I) begin
                        r_ridx <= r_ridx + IDX_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (w_out_fire) r_oidx <= r_oidx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_state == S_OUTPUT);
    assign bus.out_data  = w_odata;
    assign bus.out_index = r_oidx;
    assign bus.out_last  = (r_state == S_OUTPUT) && (r_oidx == LAST_I);
    assign busy          = (r_state != S_COLLECT);

endmodule

// File: tb/tb_sum_mod_vec.sv
// -----------------------------------------------------------------------------
// tb_sum_mod_vec
//   Directed + randomized bench for sum_mod_vec. Expected results come from a
//   plain-arithmetic model: element i = (sum of channel elements) % MODULUS,
//   reduce time = sum over elements of (sum / MODULUS + 1) cycles.
// -----------------------------------------------------------------------------
module tb_sum_mod_vec;
    localparam int N_CH    = 4;
    localparam int VEC_LEN = 6;
    localparam int DATA_W  = 9;
    localparam int MODULUS = 509;
    localparam int IDX_W   = $clog2(VEC_LEN + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic busy;

    sum_mod_vec_if #(.N_CH(N_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    sum_mod_vec #(
        .N_CH(N_CH), .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .MODULUS(MODULUS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int vec [N_CH][VEC_LEN];
    int start_d [N_CH];

    localparam logic [N_CH-1:0] ALL_RDY = '1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input int v);
        for (int c = 0; c < N_CH; c++) begin
            start_d[c] = 0;
            for (int i = 0; i < VEC_LEN; i++) vec[c][i] = v;
        end
    endtask

    task automatic fill_rand();
        for (int c = 0; c < N_CH; c++) begin
            start_d[c] = $urandom_range(0, 4);
            for (int i = 0; i < VEC_LEN; i++) vec[c][i] = $urandom_range(0, (1 << DATA_W) - 1);
        end
    endtask

    // Feed vec[][] into the channels; channels that are done keep driving
    // garbage with random valid, which the adder must ignore.
    task automatic drive_vec(input bit gaps);
        int               sent [N_CH];
        logic [N_CH-1:0]  exp_rdy;
        bit               done;
        int               cyc;
        for (int c = 0; c < N_CH; c++) sent[c] = 0;
        done = 0;
        cyc  = 0;
        exp_rdy = '0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                if (sent[c] < VEC_LEN) begin
                    bus.in_valid[c] = (cyc >= start_d[c]) && (!gaps || $urandom_range(0, 3) != 0);
                    bus.in_data[c*DATA_W +: DATA_W] = DATA_W'(vec[c][sent[c]]);
                end else begin
                    bus.in_valid[c] = 1'($urandom_range(0, 1));
                    bus.in_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
                exp_rdy[c] = (sent[c] < VEC_LEN);
            end
            #1;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("busy_collect", 32'(busy), 0);
            @(posedge clk);
            done = 1;
            for (int c = 0; c < N_CH; c++) begin
                if (bus.in_valid[c] && exp_rdy[c]) sent[c]++;
                if (sent[c] < VEC_LEN) done = 0;
            end
            cyc++;
        end
        chk("drive_done", 32'(done), 1);
        @(negedge clk);
        bus.in_valid = '0;
    endtask

    // Wait out REDUCE, then take every element; out_ready is held low for
    // stall_n cycles when element stall_idx is presented.
    task automatic recv_vec(input string tag, input int stall_idx, input int stall_n);
        int expv [VEC_LEN];
        int nred, s, cyc, ns;
        bit seen;
        nred = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            s = 0;
            for (int c = 0; c < N_CH; c++) s += vec[c][i];
            expv[i] = s % MODULUS;
            nred   += s / MODULUS + 1;
        end
        bus.out_ready = 1'b0;
        cyc  = 0;
        seen = 0;
        for (int w = 0; w < 500 && !seen; w++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) seen = 1;
            else if (busy) begin
                cyc++;
                if (cyc == 1) chk({tag, "_rdy_in_reduce"}, 32'(bus.in_ready), 0);
            end
        end
        chk({tag, "_reached_output"}, 32'(seen), 1);
        if (!seen) return;
        chk({tag, "_reduce_cycles"}, 32'(cyc), 32'(nred));
        for (int k = 0; k < VEC_LEN; k++) begin
            ns = (k == stall_idx) ? stall_n : 0;
            for (int j = 0; j <= ns; j++) begin
                bus.out_ready = (j == ns);
                chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
                chk({tag, "_out_index"}, 32'(bus.out_index), 32'(k));
                chk({tag, "_out_data"},  32'(bus.out_data),  32'(expv[k]));
                chk({tag, "_out_last"},  32'(bus.out_last),  32'(k == VEC_LEN - 1));
                @(posedge clk);
                @(negedge clk);
                #1;
            end
        end
        bus.out_ready = 1'b0;
        chk({tag, "_end_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_end_busy"},  32'(busy), 0);
        chk({tag, "_end_rdy"},   32'(bus.in_ready), 32'(ALL_RDY));
        chk({tag, "_end_index"}, 32'(bus.out_index), 0);
    endtask

    // Three beats on every channel, then abort with flush (beats still
    // offered in the flush cycle) or with an asynchronous reset pulse.
    task automatic partial_abort(input string tag, input bit use_rst);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = '1;
            bus.in_data  = {N_CH{DATA_W'(100)}};
        end
        @(negedge clk);
        if (use_rst) begin
            bus.in_valid = '0;
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            bus.in_valid = '0;
            #1;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_rdy"},   32'(bus.in_ready), 32'(ALL_RDY));
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data), 0);
        chk("rst_out_index", 32'(bus.out_index), 0);
        chk("rst_out_last",  32'(bus.out_last), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'(ALL_RDY));
        @(negedge clk);
        rst_n = 1'b1;

        // All ones
        fill_const(1);
        drive_vec(0);
        recv_vec("ones", -1, 0);

        // Worst-case inputs, heavy reduction
        fill_const((1 << DATA_W) - 1);
        drive_vec(0);
        recv_vec("max", -1, 0);

        // Exactly MODULUS and MODULUS-1 on channel 0 only
        fill_const(0);
        for (int i = 0; i < VEC_LEN; i++) vec[0][i] = (i % 2 == 0) ? MODULUS : MODULUS - 1;
        drive_vec(0);
        recv_vec("edge", -1, 0);

        // Channel 3 starts late
        fill_const(7);
        for (int i = 0; i < VEC_LEN; i++) vec[1][i] = 100 * i;
        start_d[3] = 10;
        drive_vec(0);
        recv_vec("late", -1, 0);

        // Output backpressure at index 2
        fill_rand();
        drive_vec(0);
        recv_vec("stall", 2, 3);

        // Flush after partial vector, then a clean vector
        partial_abort("flush", 0);
        fill_const(2);
        drive_vec(0);
        recv_vec("after_flush", -1, 0);

        // Reset pulse after partial vector, then a clean vector
        partial_abort("rstp", 1);
        fill_const(2);
        drive_vec(0);
        recv_vec("after_rst", -1, 0);

        // Flush while streaming the result
        fill_rand();
        drive_vec(0);
        for (int w = 0; w < 200 && !bus.out_valid; w++) begin
            @(negedge clk);
            #1;
        end
        chk("oflush_reach", 32'(bus.out_valid), 1);
        @(negedge clk);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("oflush_valid", 32'(bus.out_valid), 0);
        chk("oflush_busy",  32'(busy), 0);
        chk("oflush_index", 32'(bus.out_index), 0);
        chk("oflush_rdy",   32'(bus.in_ready), 32'(ALL_RDY));
        fill_rand();
        drive_vec(1);
        recv_vec("after_oflush", -1, 0);

        // Randomized vectors with input gaps and random backpressure
        for (int r = 0; r < 8; r++) begin
            fill_rand();
            drive_vec(1);
            recv_vec("rand", $urandom_range(0, VEC_LEN - 1), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
